seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
Two-digit time-multiplexed 7-segment display driver. It sits directly downstream of the 00–59 BCD counter and consumes its units (dv) and tens (ch) digits. It snapshots both digits once per scan frame so a frame never mixes old and new values, decodes BCD to segments, and drives segment/anode lines with a scan prescaler and anti-ghosting dead time.

Parameters:
SCAN_DIV, 1000, clk cycles per digit slot; legal range 2..65535.
DEAD_CYC, 2, cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
SEG_ACTIVE_LOW, 1, 1 = segment lit when its line is 0.
AN_ACTIVE_LOW, 1, 1 = digit enabled when its anode line is 0.

Ports:
clk  in  1  clock; all logic on the rising edge.
reset_n  in  1  asynchronous, active-low reset.
dv  in  4  units BCD digit from the counter.
ch  in  4  tens BCD digit from the counter.
blank  in  1  1 = all anodes inactive while high.
seg  out  7  segments; seg[0]=a .. seg[6]=g.
an  out  2  anodes; an[0]=units, an[1]=tens.
frame_tick  out  1  one-cycle pulse on each snapshot load.

Behaviour:
- Reset (reset_n=0, takes effect immediately):
  - prescaler p=0, digit select sel=0 (units), shadow digits sh_dv=sh_ch=0.
  - seg = all segments off, an = all anodes off, frame_tick=0.
- Prescaler:
  - p counts 0..SCAN_DIV-1 every cycle and wraps to 0.
  - At the wrap, sel toggles (0→1→0).
  - p runs regardless of blank.
- Snapshot:
  - On the edge where p==SCAN_DIV-1 and sel==1 (end of the tens slot), sh_dv<=dv, sh_ch<=ch, and frame_tick<=1 for exactly one cycle.
  - dv/ch are sampled at no other time.
  - A frame is 2*SCAN_DIV cycles.
- Outputs: registered with one-cycle latency from (sel, p, shadow, blank).
  - Anode: the anode of the sel digit is active when p>=DEAD_CYC and blank==0; otherwise both anodes are inactive.
  - Segments: seg = decode(sel ? sh_ch : sh_dv), polarity per SEG_ACTIVE_LOW.
  - Segments are driven during dead time as well; only the anodes gate visibility.
- Decode (active-high, g..a):
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Any value 10..15 decodes to 40 (dash, segment g only).
- Boundary conditions:
  - dv/ch changing on the snapshot edge: the value present at that edge is captured.
  - blank asserted mid-slot: anodes go off the next cycle; p, sel and frame_tick continue unaffected.
  - reset_n deasserted: the first frame displays "00". The first frame_tick occurs on edge 2*SCAN_DIV after release.

Optional Feature:
SEG7_LZ_BLANK_EN
- Defined: during the tens slot, if sh_ch==0, both anodes stay inactive, so 07 displays as " 7".
- Not defined: the tens digit always displays, including 0.
- The macro affects nothing else.

Test Plan:
All scenarios use SCAN_DIV=4, DEAD_CYC=1, both polarities active-low.
1. Reset: hold reset_n=0, toggle clk → seg=7'h7F, an=2'b11, frame_tick=0. Assert reset_n=0 asynchronously mid-slot → same values before the next edge.
2. Release reset with dv=7, ch=4:
   - Frame 1 units slot: an=2'b11 for 1 cycle, then 2'b10 with seg=7'h40 ("0").
   - frame_tick pulses at edge 8.
   - Frame 2: units seg=7'h78 with an=2'b10; tens seg=7'h19 with an=2'b01.
3. Change dv 3→4 in the middle of a units slot → displayed units digit stays "3" until the frame after the next frame_tick.
4. dv=4'hC → units seg=7'h3F (dash). ch=5, dv=9 → tens seg=7'h12, units seg=7'h10.
5. blank=1 for 10 cycles → an=2'b11 from the next cycle on; frame_tick keeps pulsing every 8 cycles; normal scan resumes 1 cycle after blank=0.
6. With SEG7_LZ_BLANK_EN: ch=0, dv=5 → tens slot an=2'b11, units slot an=2'b10 with seg=7'h12. Without the macro → tens slot an=2'b01 with seg=7'h40.

Source files
------------

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: two-digit time-multiplexed 7-segment driver with per-frame digit snapshot.
// Latency: seg/an are registered, one cycle after (sel, prescaler, shadow digits, blank).
// Backpressure: none; dv/ch are sampled only on the snapshot edge, and frame_tick marks each load.
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   dv, ch     units / tens BCD digits from the upstream counter
//   blank      forces both anodes inactive while high
//   seg[6:0]   segment lines, seg[0]=a .. seg[6]=g
//   an[1:0]    anode lines, an[0]=units, an[1]=tens
//   frame_tick one-cycle pulse when the shadow digits are reloaded
//
// Optional build macro SEG7_LZ_BLANK_EN: suppress a leading zero in the tens slot.

module seg7_scan_driver #(
    parameter int SCAN_DIV       = 1000,  // cycles per digit slot, 2..65535
    parameter int DEAD_CYC       = 2,     // anodes-off cycles at slot start, < SCAN_DIV
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] dv,
    input  logic [3:0] ch,
    input  logic       blank,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       frame_tick
);

    localparam logic [15:0] P_LAST  = 16'(SCAN_DIV - 1);
    localparam logic [15:0] P_DEAD  = 16'(DEAD_CYC);
    localparam logic [6:0]  SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
    localparam logic [1:0]  AN_OFF  = AN_ACTIVE_LOW  ? 2'b11 : 2'b00;

    // BCD to active-high segments (g..a); non-BCD codes show a dash.
    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h3F;
            4'd1:    s = 7'h06;
            4'd2:    s = 7'h5B;
            4'd3:    s = 7'h4F;
            4'd4:    s = 7'h66;
            4'd5:    s = 7'h6D;
            4'd6:    s = 7'h7D;
            4'd7:    s = 7'h07;
            4'd8:    s = 7'h7F;
            4'd9:    s = 7'h6F;
            default: s = 7'h40;
        endcase
        return s;
    endfunction

    // Scan state
    logic [15:0] p_q, p_d;
    logic        sel_q, sel_d;        // 0 = units slot, 1 = tens slot
    logic [3:0]  sh_dv_q, sh_dv_d;
    logic [3:0]  sh_ch_q, sh_ch_d;

    // Registered outputs
    logic [6:0]  seg_q, seg_d;
    logic [1:0]  an_q, an_d;
    logic        frame_tick_q, frame_tick_d;

    // Internal decode nets
    logic        p_wrap;
    logic        snap;
    logic        an_vis;
    logic        lz_hide;
    logic [3:0]  digit;
    logic [6:0]  seg_on;
    logic [1:0]  an_on;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q          <= '0;
            sel_q        <= 1'b0;
            sh_dv_q      <= '0;
            sh_ch_q      <= '0;
            seg_q        <= SEG_OFF;
            an_q         <= AN_OFF;
            frame_tick_q <= 1'b0;
        end else begin
            p_q          <= p_d;
            sel_q        <= sel_d;
            sh_dv_q      <= sh_dv_d;
            sh_ch_q      <= sh_ch_d;
            seg_q        <= seg_d;
            an_q         <= an_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state: prescaler, slot select, frame snapshot
    // ------------------------------------------------------------------
    always_comb begin
        p_wrap       = (p_q == P_LAST);
        // The snapshot lands at the end of the tens slot so the next frame
        // (units then tens) is drawn entirely from one captured pair.
        snap         = p_wrap && sel_q;
        p_d          = p_wrap ? 16'd0 : p_q + 16'd1;
        sel_d        = p_wrap ? ~sel_q : sel_q;
        sh_dv_d      = snap ? dv : sh_dv_q;
        sh_ch_d      = snap ? ch : sh_ch_q;
        frame_tick_d = snap;
    end

    // ------------------------------------------------------------------
    // Output decode: segments always follow the slot digit; only the
    // anodes are gated by dead time, blank and leading-zero suppression.
    // ------------------------------------------------------------------
    always_comb begin
        digit  = sel_q ? sh_ch_q : sh_dv_q;
        seg_on = bcd_to_seg(digit);
        seg_d  = SEG_ACTIVE_LOW ? ~seg_on : seg_on;

`ifdef SEG7_LZ_BLANK_EN
        lz_hide = sel_q && (sh_ch_q == 4'd0);
`else
        lz_hide = 1'b0;
`endif

        an_vis = (p_q >= P_DEAD) && !blank && !lz_hide;
        an_on  = an_vis ? (sel_q ? 2'b10 : 2'b01) : 2'b00;
        an_d   = AN_ACTIVE_LOW ? ~an_on : an_on;
    end

    assign seg        = seg_q;
    assign an         = an_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: random and directed stimulus against a cycle-count reference model.
// Latency: model predicts outputs one edge after the sampled inputs.
// Backpressure: n/a.

module tb_seg7_scan_driver;

    localparam int SD = 4;
    localparam int DC = 1;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] dv = 4'd0;
    logic [3:0] ch = 4'd0;
    logic       blank = 1'b0;
    logic [6:0] seg;
    logic [1:0] an;
    logic       frame_tick;

    int n_checks = 0;
    int n_fail   = 0;

    seg7_scan_driver #(
        .SCAN_DIV      (SD),
        .DEAD_CYC      (DC),
        .SEG_ACTIVE_LOW(1'b1),
        .AN_ACTIVE_LOW (1'b1)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .dv        (dv),
        .ch        (ch),
        .blank     (blank),
        .seg       (seg),
        .an        (an),
        .frame_tick(frame_tick)
    );

    always #5 clk = ~clk;

    // Active-high segment patterns for digits 0..9
    logic [6:0] dig_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                                  7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

    // Reference model: position inside the frame is derived from the
    // number of clock edges since reset release.
    int         n_edge;
    logic [3:0] m_dv, m_ch;
    logic [6:0] exp_seg;
    logic [1:0] exp_an;
    logic       exp_ft;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp_v, n_edge);
        end
    endtask

    task automatic model_reset();
        n_edge = 0;
        m_dv   = 4'd0;
        m_ch   = 4'd0;
    endtask

    function automatic logic [6:0] ref_seg(input logic [3:0] d);
        logic [6:0] s;
        s = (d <= 4'd9) ? dig_tab[d] : 7'h40;
        return ~s;
    endfunction

    // One clock: model the edge with the inputs present at it, then compare
    // the DUT on the following falling edge.
    task automatic step();
        int  slot_pos;
        bit  tens;
        bit  lit;
        @(posedge clk);
        slot_pos = n_edge % SD;
        tens     = ((n_edge / SD) % 2) == 1;
        exp_seg  = ref_seg(tens ? m_ch : m_dv);
        lit      = (slot_pos >= DC) && !blank;
`ifdef SEG7_LZ_BLANK_EN
        if (tens && m_ch == 4'd0) lit = 1'b0;
`endif
        exp_an   = lit ? (tens ? 2'b01 : 2'b10) : 2'b11;
        n_edge++;
        exp_ft   = (n_edge % (2 * SD)) == 0;
        if (exp_ft) begin
            m_dv = dv;
            m_ch = ch;
        end
        @(negedge clk);
        check_eq("seg", {25'd0, seg}, {25'd0, exp_seg});
        check_eq("an", {30'd0, an}, {30'd0, exp_an});
        check_eq("frame_tick", {31'd0, frame_tick}, {31'd0, exp_ft});
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_seg"}, {25'd0, seg}, 32'h7F);
        check_eq({tag, "_an"}, {30'd0, an}, 32'h3);
        check_eq({tag, "_ft"}, {31'd0, frame_tick}, 32'h0);
    endtask

    initial begin
        model_reset();

        // Reset held with clock running
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_reset_outputs("rst_hold");
        end

        // Release with dv=7, ch=4: first frame shows "00", second "47"
        dv = 4'd7;
        ch = 4'd4;
        reset_n = 1'b1;
        for (int i = 0; i < 24; i++) begin
            step();
            if (n_edge == 1) check_eq("f1_dead_an", {30'd0, an}, 32'h3);
            if (n_edge == 2) begin
                check_eq("f1_units_an", {30'd0, an}, 32'h2);
                check_eq("f1_units_seg", {25'd0, seg}, 32'h40);
            end
            if (n_edge == 8) check_eq("first_tick", {31'd0, frame_tick}, 32'h1);
            if (n_edge == 10) check_eq("f2_units_seg", {25'd0, seg}, 32'h78);
            if (n_edge == 14) check_eq("f2_tens_seg", {25'd0, seg}, 32'h19);
        end

        // dv 3 -> 4 mid units slot; shadow keeps 3 until the next snapshot
        dv = 4'd3;
        for (int i = 0; i < 10; i++) step();
        dv = 4'd4;
        for (int i = 0; i < 16; i++) step();

        // Non-BCD units digit, then ch=5/dv=9
        dv = 4'hC;
        for (int i = 0; i < 16; i++) step();
        ch = 4'd5;
        dv = 4'd9;
        for (int i = 0; i < 16; i++) step();

        // Blank for 10 cycles, then resume
        blank = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            check_eq("blank_an", {30'd0, an}, 32'h3);
        end
        blank = 1'b0;
        for (int i = 0; i < 12; i++) step();

        // Leading zero: ch=0, dv=5
        ch = 4'd0;
        dv = 4'd5;
        for (int i = 0; i < 24; i++) step();

        // Randomized digits (including non-BCD) and sporadic blank
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) dv = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) ch = 4'($urandom_range(0, 15));
            blank = ($urandom_range(0, 9) == 0);
            step();
        end
        blank = 1'b0;

        // Asynchronous reset mid-slot: outputs return before the next edge
        step();
        step();
        #2 reset_n = 1'b0;
        #1 check_reset_outputs("rst_async");
        @(negedge clk);
        check_reset_outputs("rst_async_hold");

        // Restart and run random frames again
        model_reset();
        dv = 4'd2;
        ch = 4'd0;
        reset_n = 1'b1;
        for (int i = 0; i < 120; i++) begin
            if (i % 5 == 0) dv = 4'($urandom_range(0, 15));
            if (i % 7 == 0) ch = 4'($urandom_range(0, 9));
            step();
        end

        $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
        $finish;
    end

endmodule
